wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: two Wishbone masters (m0 fetch, m1 data) sharing one slave, with a slave-ack watchdog.
// Build option: define WB_ARB_RR_EN for round-robin tie breaking in IDLE (default: m1 always wins ties).
module wb_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        iClk,
    input  logic        iRst,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat_w,
    input  logic [3:0]  m0_sel,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m0_stall,
    output logic [31:0] m0_dat_r,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat_w,
    input  logic [3:0]  m1_sel,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        m1_stall,
    output logic [31:0] m1_dat_r,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_w,
    output logic [3:0]  s_sel,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic        s_stall,
    input  logic [31:0] s_dat_r
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            grant0, grant1, timeoutHit, tiePick1;

`ifdef WB_ARB_RR_EN
    logic last_q, last_d;

    assign tiePick1 = ~last_q;
`else
    assign tiePick1 = 1'b1;
`endif

    assign grant0     = (state_q == GNT0);
    assign grant1     = (state_q == GNT1);
    assign timeoutHit = (TIMEOUT > 0) && (grant0 || grant1) && (cnt_q == CntMax);

    // A falling cyc hands the bus straight to a waiting master; a watchdog expiry always drops to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m1_cyc && (!m0_cyc || tiePick1)) state_d = GNT1;
                else if (m0_cyc)                     state_d = GNT0;
            end
            GNT0: begin
                if (timeoutHit)   state_d = IDLE;
                else if (!m0_cyc) state_d = m1_cyc ? GNT1 : IDLE;
            end
            GNT1: begin
                if (timeoutHit)   state_d = IDLE;
                else if (!m1_cyc) state_d = m0_cyc ? GNT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Any state change (including grant entry) restarts the watchdog from zero.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && state_q != IDLE) begin
            if (s_ack || s_err)                  cnt_d = '0;
            else if (s_stb && cnt_q != CntMax)   cnt_d = cnt_q + 1'b1;
            else                                 cnt_d = cnt_q;
        end
    end

`ifdef WB_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (state_d != state_q && state_d == GNT1) last_d = 1'b1;
        if (state_d != state_q && state_d == GNT0) last_d = 1'b0;
    end
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef WB_ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef WB_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    // Request and response paths are pure muxes on the registered grant; the expiry cycle kills the slave strobe.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_w  = '0;
        s_sel    = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_stall = 1'b1;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_stall = 1'b1;
        if (grant0) begin
            s_cyc    = m0_cyc & ~timeoutHit;
            s_stb    = m0_stb & ~timeoutHit;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_w  = m0_dat_w;
            s_sel    = m0_sel;
            m0_ack   = s_ack & ~timeoutHit;
            m0_err   = s_err | timeoutHit;
            m0_stall = s_stall;
        end else if (grant1) begin
            s_cyc    = m1_cyc & ~timeoutHit;
            s_stb    = m1_stb & ~timeoutHit;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_w  = m1_dat_w;
            s_sel    = m1_sel;
            m1_ack   = s_ack & ~timeoutHit;
            m1_err   = s_err | timeoutHit;
            m1_stall = s_stall;
        end
    end

endmodule
